// File: rtl/mdu_ctrl_pkg.sv
// Shared opcodes, FSM states and sizing for the multiply/divide unit.
// Imported by the interface, the iteration datapath and the controller.
package mdu_ctrl_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH  = 5;

   localparam logic [2:0] MDU_NOP   = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIXUP
   } mdu_state_e;

   function automatic logic [DATA_WIDTH-1:0] abs_val(
      input logic [DATA_WIDTH-1:0] v,
      input logic                  neg
   );
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Control-unit side bundle of the multiply/divide unit.
// The master drives requests, the slave returns status and HI/LO.
interface mdu_ctrl_if
   import mdu_ctrl_pkg::*;
   ;

   logic                  MduStart;
   logic [2:0]            MduOpcode;
   logic [DATA_WIDTH-1:0] MduOperandA;
   logic [DATA_WIDTH-1:0] MduOperandB;
   logic                  MduBusy;
   logic                  MduDone;
   logic                  MduDivByZero;
   logic [DATA_WIDTH-1:0] MduHi;
   logic [DATA_WIDTH-1:0] MduLo;

   modport master (
      output MduStart, MduOpcode, MduOperandA, MduOperandB,
      input  MduBusy, MduDone, MduDivByZero, MduHi, MduLo
   );

   modport slave (
      input  MduStart, MduOpcode, MduOperandA, MduOperandB,
      output MduBusy, MduDone, MduDivByZero, MduHi, MduLo
   );

endinterface

// File: rtl/mdu_iter_datapath.sv
// One multiply (shift-add) or restoring-divide (shift-subtract) step
// on the {hi, lo} work register, operating on magnitudes only.
module mdu_iter_datapath
   import mdu_ctrl_pkg::*;
(
   input  logic                    is_div,
   input  logic [2*DATA_WIDTH-1:0] work,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic [2*DATA_WIDTH-1:0] work_next
);

   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH:0]   diff;
   logic [2*DATA_WIDTH:0] shl;

   always_comb begin
      sum  = {1'b0, work[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, b};
      shl  = {work, 1'b0};
      diff = shl[2*DATA_WIDTH:DATA_WIDTH] - {1'b0, b};
      work_next = work;
      if (is_div) begin
         // remainder < divisor keeps diff[msb] a pure borrow flag
         if (!diff[DATA_WIDTH])
            work_next = {diff[DATA_WIDTH-1:0],
                         shl[DATA_WIDTH-1:1], 1'b1};
         else
            work_next = shl[2*DATA_WIDTH-1:0];
      end else begin
         if (work[0])
            work_next = {sum, work[DATA_WIDTH-1:1]};
         else
            work_next = {1'b0, work[2*DATA_WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, sign fixup
// and the architectural HI/LO registers.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
(
   input logic       clk,
   input logic       rstn,
   mdu_ctrl_if.slave bus
);

   localparam int W = DATA_WIDTH;

   mdu_state_e state, state_next;

   logic [CNT_WIDTH-1:0] cnt;
   logic [2*W-1:0]       work, work_next, prod_fix;
   logic [W-1:0]         b_reg, quot_fix, rem_fix;
   logic [W-1:0]         hi, lo;
   logic                 is_div, neg_q, neg_r;
   logic                 done, dbz;
   logic                 is_arith, is_signed, is_div_op;
   logic                 idle, div_zero, go, last;

   always_comb begin
      is_arith  = 1'b0;
      is_signed = 1'b0;
      is_div_op = 1'b0;
      case (bus.MduOpcode)
         MDU_MULT: begin
            is_arith  = 1'b1;
            is_signed = 1'b1;
         end
         MDU_MULTU: is_arith = 1'b1;
         MDU_DIV: begin
            is_arith  = 1'b1;
            is_signed = 1'b1;
            is_div_op = 1'b1;
         end
         MDU_DIVU: begin
            is_arith  = 1'b1;
            is_div_op = 1'b1;
         end
         MDU_NOP, MDU_MTHI, MDU_MTLO: ;
         default: ;
      endcase
   end

   assign idle     = (state == ST_IDLE);
   assign div_zero = is_div_op && (bus.MduOperandB == '0);
   assign go       = idle && bus.MduStart && is_arith && !div_zero;
   assign last     = (cnt == CNT_WIDTH'(W - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (go) state_next = ST_CALC;
         ST_CALC:  if (last) state_next = ST_FIXUP;
         ST_FIXUP: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   mdu_iter_datapath u_iter (
      .is_div    (is_div),
      .work      (work),
      .b         (b_reg),
      .work_next (work_next)
   );

   assign prod_fix = neg_q ? -work : work;
   assign quot_fix = neg_q ? -work[W-1:0] : work[W-1:0];
   assign rem_fix  = neg_r ? -work[2*W-1:W] : work[2*W-1:W];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt    <= '0;
         work   <= '0;
         b_reg  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         dbz    <= 1'b0;
      end else begin
         done <= 1'b0;
         dbz  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (go) begin
                  work <= {{W{1'b0}}, abs_val(bus.MduOperandA,
                           is_signed && bus.MduOperandA[W-1])};
                  b_reg <= abs_val(bus.MduOperandB,
                           is_signed && bus.MduOperandB[W-1]);
                  is_div <= is_div_op;
                  neg_q  <= is_signed &&
                            (bus.MduOperandA[W-1] ^ bus.MduOperandB[W-1]);
                  neg_r  <= is_signed && bus.MduOperandA[W-1];
                  cnt    <= '0;
               end else if (bus.MduStart && div_zero) begin
                  dbz <= 1'b1;
               end else if (bus.MduStart && bus.MduOpcode == MDU_MTHI) begin
                  hi <= bus.MduOperandA;
               end else if (bus.MduStart && bus.MduOpcode == MDU_MTLO) begin
                  lo <= bus.MduOperandA;
               end
            end
            ST_CALC: begin
               work <= work_next;
               cnt  <= cnt + 1'b1;
            end
            ST_FIXUP: begin
               done <= 1'b1;
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.MduBusy      = !idle;
   assign bus.MduDone      = done;
   assign bus.MduDivByZero = dbz;
   assign bus.MduHi        = hi;
   assign bus.MduLo        = lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: issued ops push expected HI/LO,
// a monitor pops on MduDone/MduDivByZero and checks timing too.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mdu_ctrl_if bus ();

   mdu_ctrl dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      bit          dbz;
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          busy_cnt = 0;
   logic [31:0] m_hi, m_lo;

   always @(posedge clk) cyc++;

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)",
                  name, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         busy_cnt = 0;
      end else begin
         if (bus.MduBusy) busy_cnt++;
         if (bus.MduDone || bus.MduDivByZero) begin
            if (q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               check("out_dbz", bus.MduDivByZero, e.dbz);
               check("out_done", bus.MduDone, !e.dbz);
               check("out_hi", bus.MduHi, e.hi);
               check("out_lo", bus.MduLo, e.lo);
               check("latency", cyc, e.due);
               check("busy_cycles", busy_cnt, e.dbz ? 0 : 33);
            end
            busy_cnt = 0;
         end else if (q.size() != 0 && cyc > q[0].due) begin
            check("result_timeout", 0, 1);
            void'(q.pop_front());
         end
      end
   end

   // Reference results from plain 64-bit integer arithmetic.
   task automatic drive_start(input logic [2:0] op,
                              input logic [31:0] a,
                              input logic [31:0] b);
      exp_t        e;
      longint      sa, sb;
      logic [63:0] p;
      bit          push;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      push  = 0;
      e.dbz = 0;
      e.due = cyc + 1 + 33;
      case (op)
         MDU_MULT: begin
            p = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
            push = 1;
         end
         MDU_MULTU: begin
            p = {32'b0, a} * {32'b0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
            push = 1;
         end
         MDU_DIV, MDU_DIVU: begin
            push = 1;
            if (b == 0) begin
               e.dbz = 1;
               e.due = cyc + 1;
            end else if (op == MDU_DIV) begin
               m_lo = 32'(sa / sb);
               m_hi = 32'(sa % sb);
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         MDU_MTHI: m_hi = a;
         MDU_MTLO: m_lo = a;
         default: ;
      endcase
      e.hi = m_hi;
      e.lo = m_lo;
      if (push) q.push_back(e);
      bus.MduStart    = 1'b1;
      bus.MduOpcode   = op;
      bus.MduOperandA = a;
      bus.MduOperandB = b;
      @(negedge clk);
      bus.MduStart = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.MduBusy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 0, 1);
   endtask

   task automatic issue(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      bit arith;
      arith = (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) &&
              !(op inside {MDU_DIV, MDU_DIVU} && b == 0);
      drive_start(op, a, b);
      if (arith) begin
         wait_idle();
      end else begin
         check("nonarith_busy", bus.MduBusy, 0);
         check("nonarith_hi", bus.MduHi, m_hi);
         check("nonarith_lo", bus.MduLo, m_lo);
      end
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bus.MduStart    = 1'b0;
      bus.MduOpcode   = MDU_NOP;
      bus.MduOperandA = '0;
      bus.MduOperandB = '0;
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.MduBusy, 0);
      check("rst_done", bus.MduDone, 0);
      check("rst_dbz", bus.MduDivByZero, 0);
      check("rst_hi", bus.MduHi, 0);
      check("rst_lo", bus.MduLo, 0);
      rstn = 1'b1;
      @(negedge clk);

      issue(MDU_MULT,  32'hFFFFFFFE, 32'd3);
      issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(MDU_DIV,   32'hFFFFFFF9, 32'd2);
      issue(MDU_DIVU,  32'hFFFFFFF9, 32'd2);
      issue(MDU_MTHI,  32'h11, 32'h0);
      issue(MDU_MTLO,  32'h22, 32'h0);
      issue(MDU_DIVU,  32'd5, 32'd0);
      issue(MDU_DIV,   32'h80000000, 32'hFFFFFFFF);
      issue(MDU_DIV,   32'd7, 32'hFFFFFFFE);
      issue(MDU_NOP,   32'h1234, 32'h5678);
      issue(3'd7,      32'h1234, 32'h5678);

      // A start while busy must be dropped, not queued.
      drive_start(MDU_MULT, 32'd1000, 32'hFFFFFF00);
      repeat (4) @(negedge clk);
      bus.MduStart    = 1'b1;
      bus.MduOpcode   = MDU_MTLO;
      bus.MduOperandA = 32'h55;
      @(negedge clk);
      bus.MduStart = 1'b0;
      wait_idle();

      drive_start(MDU_MULT, 32'h1234, 32'h5678);
      repeat (9) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_busy", bus.MduBusy, 0);
      check("midrst_hi", bus.MduHi, 0);
      check("midrst_lo", bus.MduLo, 0);
      q.delete();
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      issue(MDU_MULT, 32'd2, 32'd3);

      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'd1;
            2:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         issue(op, a, b);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Iterative multiply/divide unit with its sequencing FSM and HI/LO architectural registers. It executes MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO, sitting beside the ALU.
- The control unit issues a start pulse with rs/rt operands.
- The unit stalls the core via MduBusy until HI/LO are updated.
- One shared shift/add-subtract datapath serves all four arithmetic ops, one bit per cycle.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width
CNT_WIDTH, 5, iteration counter width; iterations = DATA_WIDTH

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
MduStart  input  1  one-cycle request from control unit
MduOpcode  input  3  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_NOP
MduOperandA  input  32  rs value (multiplicand/dividend/MT source)
MduOperandB  input  32  rt value (multiplier/divisor)
MduBusy  output  1  high while an arithmetic op is in flight; core stalls on it
MduDone  output  1  one-cycle pulse in the cycle HI/LO first show a new arithmetic result
MduDivByZero  output  1  one-cycle pulse; DIV/DIVU with divisor 0 was rejected
MduHi  output  32  HI register (MFHI source)
MduLo  output  32  LO register (MFLO source)

Behaviour:
- Reset (rstn=0, async): state=IDLE, counter=0, MduHi=0, MduLo=0, MduBusy=0, MduDone=0, MduDivByZero=0. Reset mid-operation aborts the op with no HI/LO write.
- FSM states: IDLE, CALC, FIXUP.
- IDLE + MduStart + MULT/MULTU/DIV/DIVU with nonzero divisor:
  - Latch |A| and |B| (raw values for unsigned ops), and latch result-sign flags.
  - Clear accumulator and counter=0; go to CALC.
  - MduBusy=1 from the next cycle.
- IDLE + MduStart + DIV/DIVU with B=0:
  - Stay IDLE; HI/LO unchanged.
  - MduDivByZero=1 for exactly one cycle; MduDone stays 0; MduBusy stays 0.
- IDLE + MduStart + MTHI/MTLO: write A to HI or LO at that edge; no busy, no done.
- MduStart with MDU_NOP or an undefined opcode: ignored.
- MduStart while MduBusy=1: ignored; no queuing.
- CALC: one iteration per cycle for 32 cycles (counter 0..31); at counter=31 go to FIXUP.
  - Multiply: shift-add on a 64-bit product register.
  - Divide: restoring shift-subtract; quotient built in the low half, remainder in the high half.
- FIXUP: apply signs, then write HI/LO and go to IDLE.
  - MULT: negate the 64-bit product if sign(A)^sign(B).
  - DIV: quotient negated if sign(A)^sign(B); remainder takes the sign of A.
  - Result: HI=product[63:32] or remainder; LO=product[31:0] or quotient.
  - MduBusy drops and MduDone=1 for one cycle.
- Latency: start edge T; result and MduDone visible after edge T+33. MduBusy is high for 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap, no flag.
- MduHi/MduLo hold their values between ops. No arithmetic exceptions are raised; overflow is architecturally undefined in MIPS and is not flagged.

Decomposition:
- Shared define header gets the MDU_* opcode constants (3-bit) and the FSM state encodings, alongside the existing ALU/memory control defines.
- One natural sub-module: mdu_iter_datapath.
  - Combinational single-step multiply/divide iteration: 64-bit work register and B in, next work register out, op select.
  - Keeps mdu_ctrl as FSM, counter, sign fixup and HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3 -> MduBusy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, MduDone pulses once.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at T+33.
- DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- DIVU A=5, B=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> MduDivByZero one-cycle pulse, MduBusy never set, HI=0x11, LO=0x22.
- MULT started, second MduStart (MTLO A=0x55) at cycle T+5 -> ignored; final LO is the product, not 0x55.
- MULT started, rstn pulsed low at T+10 -> immediately MduBusy=0, HI=LO=0, state IDLE; next MULT 2*3 gives LO=6, HI=0.
